// File: rtl/rs485_pkg.sv
// Shared types and default timing for the RS-485 transmit sequencer.
package rs485_pkg;

   localparam int BYTE_W         = 8;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_IDLE_GAP   = 22;
   localparam int DEF_SETUP_CYC  = 4;
   localparam int DEF_HOLD_CYC   = 4;
   localparam int DEF_TX_TIMEOUT = 1024;
   localparam int DEF_CNT_W      = 8;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_BUS_WAIT = 4'd1,
      ST_DE_SETUP = 4'd2,
      ST_FETCH    = 4'd3,
      ST_LOAD     = 4'd4,
      ST_SEND_HI  = 4'd5,
      ST_WAIT_HI  = 4'd6,
      ST_SEND_LO  = 4'd7,
      ST_WAIT_LO  = 4'd8,
      ST_DE_HOLD  = 4'd9
   } seq_state_e;

   // The driver owns the line from the start of the setup guard to the end of the hold guard.
   function automatic logic de_active(input seq_state_e st);
      logic act;
      case (st)
         ST_IDLE:     act = 1'b0;
         ST_BUS_WAIT: act = 1'b0;
         ST_DE_SETUP: act = 1'b1;
         ST_FETCH:    act = 1'b1;
         ST_LOAD:     act = 1'b1;
         ST_SEND_HI:  act = 1'b1;
         ST_WAIT_HI:  act = 1'b1;
         ST_SEND_LO:  act = 1'b1;
         ST_WAIT_LO:  act = 1'b1;
         ST_DE_HOLD:  act = 1'b1;
         default:     act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/rs485_cycle_timer.sv
// Down-counting cycle timer: load a start value, count down to zero, flag zero.
// Load has priority over clear so a timer can be re-armed on the same cycle
// the owning state is being left.
module rs485_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Counter register: reset, load, clear, or decrement while above zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/rs485_tx_sequencer.sv
// RS-485 half-duplex transmit sequencer: waits for an idle bus, raises DE with
// a setup guard, pops FIFO words and sends them high byte first through the
// byte transmitter, then holds DE for a guard time before releasing the line.
// All outputs are registered from the next-state decode so they line up with
// the state register and never glitch.
module rs485_tx_sequencer
   import rs485_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int IDLE_GAP   = DEF_IDLE_GAP,
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int TX_TIMEOUT = DEF_TX_TIMEOUT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              cfg_enable,
   input  logic              clr_err,
   input  logic              rx_busy,
   input  logic              fifo_empty,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_byte,
   input  logic              tx_done,
   output logic              Tx_Enable,
   output logic              busy,
   output logic [CNT_W-1:0]  words_sent,
   output logic              err_timeout
);

   localparam int GUARD_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int IG_W      = $clog2(IDLE_GAP + 1);
   localparam int GD_W      = $clog2(GUARD_MAX + 1);
   localparam int TO_W      = $clog2(TX_TIMEOUT + 1);

   // Timers count down from N-1 so that the owning state lasts exactly N cycles.
   localparam logic [IG_W-1:0] IDLE_LOAD  = IG_W'(IDLE_GAP - 1);
   localparam logic [GD_W-1:0] SETUP_LOAD = GD_W'(SETUP_CYC - 1);
   localparam logic [GD_W-1:0] HOLD_LOAD  = GD_W'(HOLD_CYC - 1);
   localparam logic [TO_W-1:0] TO_LOAD    = TO_W'(TX_TIMEOUT - 1);

   seq_state_e state_r;
   seq_state_e state_next_s;

   logic [DATA_W-1:0] word_r;
   logic [BYTE_W-1:0] tx_byte_r;
   logic [BYTE_W-1:0] byte_s;
   logic [CNT_W-1:0]  words_sent_r;
   logic              tx_enable_r;
   logic              busy_r;
   logic              fifo_rd_r;
   logic              tx_start_r;
   logic              err_timeout_r;

   logic              start_s;
   logic              word_load_s;
   logic              sent_inc_s;
   logic              err_set_s;

   logic              idle_load_s;
   logic              idle_dec_s;
   logic              idle_clr_s;
   logic              idle_zero_s;
   logic              guard_load_s;
   logic [GD_W-1:0]   guard_val_s;
   logic              guard_dec_s;
   logic              guard_clr_s;
   logic              guard_zero_s;
   logic              to_load_s;
   logic              to_dec_s;
   logic              to_clr_s;
   logic              to_zero_s;

   assign idle_clr_s  = (state_r != ST_BUS_WAIT);
   assign guard_clr_s = (state_r != ST_DE_SETUP) && (state_r != ST_DE_HOLD);
   assign to_clr_s    = (state_r != ST_WAIT_HI) && (state_r != ST_WAIT_LO);

   rs485_cycle_timer #(.W(IG_W)) u_idle_timer (
      .clk      (PCLK),
      .rst_n    (PRESETN),
      .clr      (idle_clr_s),
      .load     (idle_load_s),
      .load_val (IDLE_LOAD),
      .dec      (idle_dec_s),
      .zero     (idle_zero_s)
   );

   rs485_cycle_timer #(.W(GD_W)) u_guard_timer (
      .clk      (PCLK),
      .rst_n    (PRESETN),
      .clr      (guard_clr_s),
      .load     (guard_load_s),
      .load_val (guard_val_s),
      .dec      (guard_dec_s),
      .zero     (guard_zero_s)
   );

   rs485_cycle_timer #(.W(TO_W)) u_timeout_timer (
      .clk      (PCLK),
      .rst_n    (PRESETN),
      .clr      (to_clr_s),
      .load     (to_load_s),
      .load_val (TO_LOAD),
      .dec      (to_dec_s),
      .zero     (to_zero_s)
   );

   // Next-state, timer control and per-cycle datapath strobes.
   always_comb begin
      state_next_s = state_r;
      idle_load_s  = 1'b0;
      idle_dec_s   = 1'b0;
      guard_load_s = 1'b0;
      guard_val_s  = SETUP_LOAD;
      guard_dec_s  = 1'b0;
      to_load_s    = 1'b0;
      to_dec_s     = 1'b0;
      start_s      = 1'b0;
      byte_s       = tx_byte_r;
      word_load_s  = 1'b0;
      sent_inc_s   = 1'b0;
      err_set_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cfg_enable && !fifo_empty && !err_timeout_r) begin
               state_next_s = ST_BUS_WAIT;
               idle_load_s  = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUS_WAIT: begin
            if (!cfg_enable) begin
               state_next_s = ST_IDLE;
            end else if (rx_busy) begin
               idle_load_s = 1'b1;
            end else if (idle_zero_s) begin
               state_next_s = ST_DE_SETUP;
               guard_load_s = 1'b1;
               guard_val_s  = SETUP_LOAD;
            end else begin
               idle_dec_s = 1'b1;
            end
         end
         ST_DE_SETUP: begin
            if (guard_zero_s) begin
               // Never pop an empty FIFO; release the line instead.
               if (fifo_empty) begin
                  state_next_s = ST_DE_HOLD;
                  guard_load_s = 1'b1;
                  guard_val_s  = HOLD_LOAD;
               end else begin
                  state_next_s = ST_FETCH;
               end
            end else begin
               guard_dec_s = 1'b1;
            end
         end
         ST_FETCH: begin
            state_next_s = ST_LOAD;
         end
         ST_LOAD: begin
            word_load_s  = 1'b1;
            state_next_s = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            if (tx_ready) begin
               start_s      = 1'b1;
               byte_s       = word_r[DATA_W-1 -: BYTE_W];
               to_load_s    = 1'b1;
               state_next_s = ST_WAIT_HI;
            end else begin
               state_next_s = ST_SEND_HI;
            end
         end
         ST_WAIT_HI: begin
            if (tx_done) begin
               state_next_s = ST_SEND_LO;
            end else if (to_zero_s) begin
               err_set_s    = 1'b1;
               state_next_s = ST_DE_HOLD;
               guard_load_s = 1'b1;
               guard_val_s  = HOLD_LOAD;
            end else begin
               to_dec_s = 1'b1;
            end
         end
         ST_SEND_LO: begin
            if (tx_ready) begin
               start_s      = 1'b1;
               byte_s       = word_r[BYTE_W-1:0];
               to_load_s    = 1'b1;
               state_next_s = ST_WAIT_LO;
            end else begin
               state_next_s = ST_SEND_LO;
            end
         end
         ST_WAIT_LO: begin
            if (tx_done) begin
               sent_inc_s = 1'b1;
               // Back-to-back words keep DE high and skip the idle wait.
               if (cfg_enable && !fifo_empty) begin
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_DE_HOLD;
                  guard_load_s = 1'b1;
                  guard_val_s  = HOLD_LOAD;
               end
            end else if (to_zero_s) begin
               err_set_s    = 1'b1;
               state_next_s = ST_DE_HOLD;
               guard_load_s = 1'b1;
               guard_val_s  = HOLD_LOAD;
            end else begin
               to_dec_s = 1'b1;
            end
         end
         ST_DE_HOLD: begin
            if (guard_zero_s) begin
               state_next_s = ST_IDLE;
            end else begin
               guard_dec_s = 1'b1;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Registered control outputs decoded from the state being entered.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         tx_enable_r <= 1'b0;
         busy_r      <= 1'b0;
         fifo_rd_r   <= 1'b0;
         tx_start_r  <= 1'b0;
         tx_byte_r   <= {BYTE_W{1'b0}};
      end else begin
         tx_enable_r <= de_active(state_next_s);
         busy_r      <= (state_next_s != ST_IDLE);
         fifo_rd_r   <= (state_next_s == ST_FETCH);
         tx_start_r  <= start_s;
         tx_byte_r   <= byte_s;
      end
   end

   // Word latch: FIFO data is valid the cycle after the pop strobe.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         word_r <= {DATA_W{1'b0}};
      end else if (word_load_s) begin
         word_r <= fifo_rdata;
      end else begin
         word_r <= word_r;
      end
   end

   // Completed-word counter, wrapping naturally.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         words_sent_r <= {CNT_W{1'b0}};
      end else if (sent_inc_s) begin
         words_sent_r <= words_sent_r + CNT_W'(1);
      end else begin
         words_sent_r <= words_sent_r;
      end
   end

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         err_timeout_r <= 1'b0;
      end else if (err_set_s) begin
         err_timeout_r <= 1'b1;
      end else if (clr_err) begin
         err_timeout_r <= 1'b0;
      end else begin
         err_timeout_r <= err_timeout_r;
      end
   end

   assign Tx_Enable   = tx_enable_r;
   assign busy        = busy_r;
   assign fifo_rd     = fifo_rd_r;
   assign tx_start    = tx_start_r;
   assign tx_byte     = tx_byte_r;
   assign words_sent  = words_sent_r;
   assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_rs485_tx_sequencer.sv
// Directed bench for rs485_tx_sequencer with a small FIFO and byte-transmitter
// model driven from the stimulus process itself.
module tb_rs485_tx_sequencer;

   localparam int IDLE_GAP   = 22;
   localparam int SETUP_CYC  = 4;
   localparam int HOLD_CYC   = 4;
   localparam int TX_TIMEOUT = 1024;
   localparam int TX_LAT     = 12;

   logic        PCLK = 1'b0;
   logic        PRESETN;
   logic        cfg_enable;
   logic        clr_err;
   logic        rx_busy;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [15:0] fifo_rdata;
   logic        tx_ready;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic        Tx_Enable;
   logic        busy;
   logic [7:0]  words_sent;
   logic        err_timeout;

   rs485_tx_sequencer dut (
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .cfg_enable  (cfg_enable),
      .clr_err     (clr_err),
      .rx_busy     (rx_busy),
      .fifo_empty  (fifo_empty),
      .fifo_rd     (fifo_rd),
      .fifo_rdata  (fifo_rdata),
      .tx_ready    (tx_ready),
      .tx_start    (tx_start),
      .tx_byte     (tx_byte),
      .tx_done     (tx_done),
      .Tx_Enable   (Tx_Enable),
      .busy        (busy),
      .words_sent  (words_sent),
      .err_timeout (err_timeout)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int failures = 0;

   logic [15:0] q[$];
   logic [7:0]  bytes[$];
   int cyc = 0;
   int starts = 0;
   int rd_cnt = 0;
   int empty_pop = 0;
   int de_rise = 0;
   int de_fall = 0;
   int de_rise_cyc = 0;
   int de_fall_cyc = 0;
   int first_start_cyc = -1;
   int last_start_cyc = 0;
   int done_cyc = 0;
   int err_rise_cyc = 0;
   int tx_cnt = 0;
   bit pop_pend = 1'b0;
   bit withhold = 1'b0;
   bit de_prev = 1'b0;
   bit err_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs 1 time unit after the edge, then react as FIFO and transmitter.
   task automatic tick();
      @(posedge PCLK);
      #1;
      cyc++;
      if (pop_pend) begin
         if (q.size() > 0) fifo_rdata = q.pop_front();
         else empty_pop++;
         pop_pend = 1'b0;
      end
      if (fifo_rd) begin
         rd_cnt++;
         pop_pend = 1'b1;
      end
      fifo_empty = (q.size() == 0);
      tx_done = 1'b0;
      if (tx_start) begin
         starts++;
         bytes.push_back(tx_byte);
         if (first_start_cyc < 0) first_start_cyc = cyc;
         last_start_cyc = cyc;
         tx_ready = 1'b0;
         tx_cnt = TX_LAT;
      end else if (!tx_ready && tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0 && !withhold) begin
            tx_done = 1'b1;
            tx_ready = 1'b1;
            done_cyc = cyc;
         end
      end
      if (Tx_Enable && !de_prev) begin de_rise++; de_rise_cyc = cyc; end
      if (!Tx_Enable && de_prev) begin de_fall++; de_fall_cyc = cyc; end
      de_prev = Tx_Enable;
      if (err_timeout && !err_prev) err_rise_cyc = cyc;
      err_prev = err_timeout;
   endtask

   task automatic wait_busy(input string tag, input int limit);
      int n = 0;
      while (!busy && n < limit) begin tick(); n++; end
      check(tag, 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin tick(); n++; end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_start(input string tag, input int target, input int limit);
      int n = 0;
      while (starts < target && n < limit) begin tick(); n++; end
      check(tag, 32'(starts >= target), 32'd1);
   endtask

   task automatic push(input logic [15:0] w);
      q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_stats();
      bytes.delete();
      starts = 0;
      rd_cnt = 0;
      de_rise = 0;
      de_fall = 0;
      first_start_cyc = -1;
   endtask

   initial begin
      int b;
      int last_rx;
      int s_cyc;
      int n;
      PRESETN    = 1'b0;
      cfg_enable = 1'b1;
      clr_err    = 1'b0;
      rx_busy    = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = 16'h0000;
      tx_ready   = 1'b1;
      tx_done    = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_de", 32'(Tx_Enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_words", 32'(words_sent), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_byte", 32'(tx_byte), 32'd0);
      PRESETN = 1'b1;
      tick();

      // Single word A55A, bus idle
      clear_stats();
      push(16'hA55A);
      wait_busy("t1_busy", 10);
      b = cyc;
      wait_idle("t1_idle", 300);
      check("t1_de_latency", 32'(de_rise_cyc - b), 32'(IDLE_GAP));
      check("t1_start_latency", 32'(first_start_cyc - b), 32'(IDLE_GAP + SETUP_CYC + 3));
      check("t1_starts", 32'(starts), 32'd2);
      check("t1_byte_hi", 32'(bytes[0]), 32'h0A5);
      check("t1_byte_lo", 32'(bytes[1]), 32'h05A);
      check("t1_words", 32'(words_sent), 32'd1);
      check("t1_rd", 32'(rd_cnt), 32'd1);
      check("t1_de_hold", 32'(de_fall_cyc - done_cyc), 32'(HOLD_CYC + 1));
      check("t1_de_low", 32'(Tx_Enable), 32'd0);

      // Three words back to back in one DE window
      clear_stats();
      push(16'h1234);
      push(16'hBEEF);
      push(16'h0F0F);
      wait_busy("t2_busy", 10);
      wait_idle("t2_idle", 400);
      check("t2_starts", 32'(starts), 32'd6);
      check("t2_rd", 32'(rd_cnt), 32'd3);
      check("t2_de_rise", 32'(de_rise), 32'd1);
      check("t2_de_fall", 32'(de_fall), 32'd1);
      check("t2_words", 32'(words_sent), 32'd4);
      check("t2_b0", 32'(bytes[0]), 32'h012);
      check("t2_b1", 32'(bytes[1]), 32'h034);
      check("t2_b2", 32'(bytes[2]), 32'h0BE);
      check("t2_b3", 32'(bytes[3]), 32'h0EF);
      check("t2_b4", 32'(bytes[4]), 32'h00F);
      check("t2_b5", 32'(bytes[5]), 32'h00F);

      // rx_busy every 10 cycles keeps DE off; DE follows IDLE_GAP cycles after the last pulse
      clear_stats();
      push(16'h6B3D);
      wait_busy("t3_busy", 10);
      last_rx = 0;
      for (int p = 0; p < 10; p++) begin
         rx_busy = 1'b1;
         last_rx = cyc;
         tick();
         rx_busy = 1'b0;
         repeat (9) tick();
      end
      check("t3_no_de", 32'(de_rise), 32'd0);
      wait_idle("t3_idle", 300);
      check("t3_de_after_rx", 32'(de_rise_cyc - last_rx), 32'(IDLE_GAP + 1));
      check("t3_words", 32'(words_sent), 32'd5);
      check("t3_b0", 32'(bytes[0]), 32'h06B);
      check("t3_b1", 32'(bytes[1]), 32'h03D);

      // Withheld tx_done: timeout, DE drop, no further pop until clr_err
      clear_stats();
      withhold = 1'b1;
      push(16'hC33C);
      push(16'h7E81);
      wait_start("t4_start", 1, 200);
      s_cyc = last_start_cyc;
      n = 0;
      while (!err_timeout && n < TX_TIMEOUT + 100) begin tick(); n++; end
      check("t4_err", 32'(err_timeout), 32'd1);
      check("t4_err_time", 32'(err_rise_cyc - s_cyc), 32'(TX_TIMEOUT));
      check("t4_first_byte", 32'(bytes[0]), 32'h0C3);
      wait_idle("t4_idle", 20);
      check("t4_de_hold", 32'(de_fall_cyc - err_rise_cyc), 32'(HOLD_CYC));
      check("t4_words", 32'(words_sent), 32'd5);
      repeat (50) tick();
      check("t4_stay_idle", 32'(busy), 32'd0);
      check("t4_rd_held", 32'(rd_cnt), 32'd1);
      check("t4_q_left", 32'(q.size()), 32'd1);
      withhold = 1'b0;
      tx_ready = 1'b1;
      tx_cnt = 0;
      bytes.delete();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("t4_err_clr", 32'(err_timeout), 32'd0);
      wait_busy("t4_busy2", 10);
      wait_idle("t4_idle2", 300);
      check("t4_rd_after", 32'(rd_cnt), 32'd2);
      check("t4_words_after", 32'(words_sent), 32'd6);
      check("t4_b_hi", 32'(bytes[0]), 32'h07E);
      check("t4_b_lo", 32'(bytes[1]), 32'h081);

      // cfg_enable dropped in WAIT_HI: current word completes, second stays queued
      clear_stats();
      push(16'h3C5A);
      push(16'h9966);
      wait_busy("t5_busy", 10);
      wait_start("t5_start", 1, 200);
      cfg_enable = 1'b0;
      wait_idle("t5_idle", 300);
      check("t5_starts", 32'(starts), 32'd2);
      check("t5_b_lo", 32'(bytes[1]), 32'h05A);
      check("t5_words", 32'(words_sent), 32'd7);
      check("t5_rd", 32'(rd_cnt), 32'd1);
      check("t5_q_left", 32'(q.size()), 32'd1);

      // Reset during WAIT_LO
      clear_stats();
      cfg_enable = 1'b1;
      wait_busy("t6_busy", 10);
      wait_start("t6_start", 2, 300);
      PRESETN = 1'b0;
      tick();
      check("t6_de", 32'(Tx_Enable), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_start", 32'(tx_start), 32'd0);
      check("t6_words", 32'(words_sent), 32'd0);
      cfg_enable = 1'b0;
      repeat (2) tick();
      PRESETN = 1'b1;
      repeat (40) tick();
      check("t6_no_more_start", 32'(starts), 32'd2);
      check("t6_stay_idle", 32'(busy), 32'd0);
      check("empty_pops", 32'(empty_pop), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
